// File: rtl/tbs_uart_cmd_rx.sv
// tbs_uart_cmd_rx: UART byte receiver with 2-bit opcode command decoder driving TBS mode bits and pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 (8E1 instead of 8N1).
module tbs_uart_cmd_rx #(
  parameter int CLK_FREQ     = 8000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       trigger_start_mode_o,
  output logic       adaptive_mode_o,
  output logic       signal_select_o,
  output logic       enable_o,
  output logic       select_tbs_delta_steps_o,
  output logic       trigger_start_sampling_o,
  output logic       soft_reset_o,
  output logic       cmd_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state;
  logic [1:0] sync, primed;
  logic armed;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [4:0] mode;
  logic rx_s, tick;
  logic [1:0] op;
  assign rx_s = sync[1];
  assign tick = cnt == LAST;
  assign op = rx_data_o[7:6];
  assign {select_tbs_delta_steps_o, enable_o, signal_select_o, adaptive_mode_o, trigger_start_mode_o} = mode;
  // armed only rises once the synchronizer holds real samples that show an idle-high line
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      sync <= 2'b11;
      primed <= 2'b00;
      armed <= 1'b0;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync <= {sync[0], uart_rx_i};
      primed <= {primed[0], 1'b1};
      armed <= armed | (primed[1] & rx_s);
      rx_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          bit_cnt <= '0;
          if (armed && !rx_s) state <= START;
        end
        START: begin
          cnt <= (cnt == HALF) ? '0 : cnt + CW'(1);
          if (cnt == HALF) state <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            shift <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            frame_err_o <= rx_s != ^shift;
            state <= (rx_s != ^shift) ? BREAK : STOP;
          end
        end
`endif
        STOP: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            if (rx_s) rx_data_o <= shift;
            rx_valid_o <= rx_s;
            frame_err_o <= !rx_s;
            state <= rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode <= '0;
      trigger_start_sampling_o <= 1'b0;
      soft_reset_o <= 1'b0;
      cmd_err_o <= 1'b0;
    end else begin
      trigger_start_sampling_o <= rx_valid_o && op == 2'b01;
      soft_reset_o <= rx_valid_o && op == 2'b10;
      cmd_err_o <= rx_valid_o && op == 2'b11;
      if (rx_valid_o && op == 2'b00) mode <= rx_data_o[4:0];
      else if (rx_valid_o && op == 2'b10) mode <= '0;
    end
  end
endmodule

// File: tb/tb_tbs_uart_cmd_rx.sv
// tb_tbs_uart_cmd_rx: directed UART frames with hand-computed command decode expectations.
module tb_tbs_uart_cmd_rx;
  localparam int CPB = 69;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, tsm, am, ss, en, tss, trig, srst, cerr;
  logic [4:0] mode;
  int checks = 0, errors = 0;
  int cyc = 0, n_valid = 0, n_ferr = 0, n_trig = 0, n_srst = 0, n_cerr = 0;
  int valid_cyc = -10, trig_cyc = -10, srst_cyc = -10, cerr_cyc = -10;
  logic [4:0] mode_at_valid = '0, mode_after_valid = '0;
  logic prev_valid = 1'b0;
  tbs_uart_cmd_rx dut (
    .clock_i(clk), .reset_n_i(rst_n), .uart_rx_i(rx), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .frame_err_o(frame_err), .trigger_start_mode_o(tsm), .adaptive_mode_o(am), .signal_select_o(ss),
    .enable_o(en), .select_tbs_delta_steps_o(tss), .trigger_start_sampling_o(trig),
    .soft_reset_o(srst), .cmd_err_o(cerr)
  );
  always #5 clk = ~clk;
  assign mode = {tss, en, ss, am, tsm};
  always @(negedge clk) begin
    cyc++;
    if (prev_valid) mode_after_valid = mode;
    prev_valid = rx_valid;
    if (rx_valid) begin n_valid++; valid_cyc = cyc; mode_at_valid = mode; end
    if (frame_err) n_ferr++;
    if (trig) begin n_trig++; trig_cyc = cyc; end
    if (srst) begin n_srst++; srst_cyc = cyc; end
    if (cerr) begin n_cerr++; cerr_cyc = cyc; end
  end
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic uart_send(input logic [7:0] b, input int stop_low, input logic par_flip, input int gap);
    rx = 1'b0;
    clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clks(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b ^ par_flip;
    clks(CPB);
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      clks(CPB * stop_low);
    end
    rx = 1'b1;
    clks(CPB + gap);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    clks(3);
    checks += 3;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    if (mode !== 5'h00) begin errors++; $display("FAIL reset_mode got %b want 00000", mode); end
    if ({rx_valid, frame_err, trig, srst, cerr} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 00000", {rx_valid, frame_err, trig, srst, cerr});
    end
    rst_n = 1'b1;
    clks(5);
  endtask
  task automatic test_mode_load;
    int v0 = n_valid;
    uart_send(8'h1A, 0, 1'b0, 20);
    checks += 4;
    if (n_valid - v0 !== 1) begin errors++; $display("FAIL mode_valid_count got %0d want 1", n_valid - v0); end
    if (rx_data !== 8'h1A) begin errors++; $display("FAIL mode_data got %h want 1a", rx_data); end
    if (mode_at_valid !== 5'b00000) begin errors++; $display("FAIL mode_early got %b want 00000", mode_at_valid); end
    if (mode_after_valid !== 5'b11010) begin errors++; $display("FAIL mode_load got %b want 11010", mode_after_valid); end
  endtask
  task automatic test_trigger;
    int t0 = n_trig;
    uart_send(8'h40, 0, 1'b0, 20);
    checks += 3;
    if (n_trig - t0 !== 1) begin errors++; $display("FAIL trig_width got %0d want 1", n_trig - t0); end
    if (trig_cyc !== valid_cyc + 1) begin errors++; $display("FAIL trig_timing got %0d want %0d", trig_cyc, valid_cyc + 1); end
    if (mode !== 5'b11010) begin errors++; $display("FAIL trig_mode got %b want 11010", mode); end
  endtask
  task automatic test_glitch;
    int v0 = n_valid, f0 = n_ferr;
    rx = 1'b0;
    clks(20);
    rx = 1'b1;
    clks(300);
    checks += 2;
    if (n_valid - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", n_valid - v0); end
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - f0); end
  endtask
  task automatic test_break;
    int v0 = n_valid, f0 = n_ferr, s0;
    uart_send(8'h55, 3, 1'b0, 20);
    checks += 2;
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL break_ferr got %0d want 1", n_ferr - f0); end
    if (n_valid - v0 !== 0) begin errors++; $display("FAIL break_valid got %0d want 0", n_valid - v0); end
    v0 = n_valid;
    s0 = n_srst;
    uart_send(8'h80, 0, 1'b0, 20);
    checks += 5;
    if (n_valid - v0 !== 1) begin errors++; $display("FAIL srst_valid got %0d want 1", n_valid - v0); end
    if (rx_data !== 8'h80) begin errors++; $display("FAIL srst_data got %h want 80", rx_data); end
    if (n_srst - s0 !== 1) begin errors++; $display("FAIL srst_width got %0d want 1", n_srst - s0); end
    if (srst_cyc !== valid_cyc + 1) begin errors++; $display("FAIL srst_timing got %0d want %0d", srst_cyc, valid_cyc + 1); end
    if (mode !== 5'b00000) begin errors++; $display("FAIL srst_mode got %b want 00000", mode); end
  endtask
  task automatic test_back_to_back;
    int v0 = n_valid, t0 = n_trig;
    uart_send(8'h01, 0, 1'b0, 0);
    uart_send(8'h41, 0, 1'b0, 20);
    checks += 4;
    if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid got %0d want 2", n_valid - v0); end
    if (n_trig - t0 !== 1) begin errors++; $display("FAIL b2b_trig got %0d want 1", n_trig - t0); end
    if (rx_data !== 8'h41) begin errors++; $display("FAIL b2b_data got %h want 41", rx_data); end
    if (mode !== 5'b00001) begin errors++; $display("FAIL b2b_mode got %b want 00001", mode); end
  endtask
  task automatic test_reset_midframe;
    int v0, c0;
    uart_send(8'h1F, 0, 1'b0, 20);
    checks += 1;
    if (mode !== 5'b11111) begin errors++; $display("FAIL pre_reset_mode got %b want 11111", mode); end
    v0 = n_valid;
    c0 = n_cerr;
    fork
      uart_send(8'h0F, 0, 1'b0, 20);
      begin
        clks(5 * CPB + 20);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", rx_data); end
        if (mode !== 5'h00) begin errors++; $display("FAIL midrst_mode got %b want 00000", mode); end
        if ({rx_valid, frame_err, trig, srst, cerr} !== 5'b0) begin
          errors++; $display("FAIL midrst_pulses got %b want 00000", {rx_valid, frame_err, trig, srst, cerr});
        end
        clks(30);
        rst_n = 1'b1;
      end
    join
    uart_send(8'hC0, 0, 1'b0, 20);
    checks += 5;
    if (n_valid - v0 !== 1) begin errors++; $display("FAIL cerr_valid got %0d want 1", n_valid - v0); end
    if (rx_data !== 8'hC0) begin errors++; $display("FAIL cerr_data got %h want c0", rx_data); end
    if (n_cerr - c0 !== 1) begin errors++; $display("FAIL cerr_width got %0d want 1", n_cerr - c0); end
    if (cerr_cyc !== valid_cyc + 1) begin errors++; $display("FAIL cerr_timing got %0d want %0d", cerr_cyc, valid_cyc + 1); end
    if (mode !== 5'b00000) begin errors++; $display("FAIL cerr_mode got %b want 00000", mode); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0 = n_valid, f0 = n_ferr;
    uart_send(8'h03, 0, 1'b1, 20);
    checks += 3;
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL par_ferr got %0d want 1", n_ferr - f0); end
    if (n_valid - v0 !== 0) begin errors++; $display("FAIL par_valid got %0d want 0", n_valid - v0); end
    if (mode !== 5'b00000) begin errors++; $display("FAIL par_bad_mode got %b want 00000", mode); end
    v0 = n_valid;
    uart_send(8'h03, 0, 1'b0, 20);
    checks += 2;
    if (n_valid - v0 !== 1) begin errors++; $display("FAIL par_ok_valid got %0d want 1", n_valid - v0); end
    if (mode !== 5'b00011) begin errors++; $display("FAIL par_ok_mode got %b want 00011", mode); end
  endtask
`endif
  initial begin
    test_reset;
    test_mode_load;
    test_trigger;
    test_glitch;
    test_break;
    test_back_to_back;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
